// File: rtl/layer_argmax_seq.sv
// Streaming argmax over NUM_IN float32 values per frame; result held until consumed.
// Optional runner-up tracking is enabled by defining ARGMAX_TOP2_EN.
module layer_argmax_seq #(
    parameter int NUM_IN = 12,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [31:0]      out_max
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [IDX_W-1:0] out_idx2,
    output logic [31:0]      out_max2
`endif
);

    typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       max_q, max_d;
    logic              accept;

    // Strict float greater-than; NaN never wins, anything beats a stored NaN, +0 == -0.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan) return 1'b0;
        if (b_nan) return 1'b1;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        case ({a[31], b[31]})
            2'b00:   return a[30:0] > b[30:0];
            2'b01:   return 1'b1;
            2'b10:   return 1'b0;
            default: return a[30:0] < b[30:0];
        endcase
    endfunction

`ifdef ARGMAX_TOP2_EN
    logic [IDX_W-1:0]  idx2_q, idx2_d;
    logic [31:0]       max2_q, max2_d;
    logic              s2v_q, s2v_d;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        max_d     = max_q;
`ifdef ARGMAX_TOP2_EN
        idx2_d    = idx2_q;
        max2_d    = max2_q;
        s2v_d     = s2v_q;
`endif
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == DONE);
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (cnt_q == '0) begin
                        max_d = in_data;
                        idx_d = '0;
`ifdef ARGMAX_TOP2_EN
                        s2v_d = 1'b0;
`endif
                    end else if (gt(in_data, max_q)) begin
`ifdef ARGMAX_TOP2_EN
                        max2_d = max_q;
                        idx2_d = idx_q;
                        s2v_d  = 1'b1;
`endif
                        max_d = in_data;
                        idx_d = cnt_q;
                    end
`ifdef ARGMAX_TOP2_EN
                    // Losers to the leader may still take the runner-up slot.
                    else if (!s2v_q || gt(in_data, max2_q)) begin
                        max2_d = in_data;
                        idx2_d = cnt_q;
                        s2v_d  = 1'b1;
                    end
`endif
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
`ifdef ARGMAX_TOP2_EN
            idx2_q  <= '0;
            max2_q  <= '0;
            s2v_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
`ifdef ARGMAX_TOP2_EN
            idx2_q  <= idx2_d;
            max2_q  <= max2_d;
            s2v_q   <= s2v_d;
`endif
        end
    end

    assign out_idx  = idx_q;
    assign out_max  = max_q;
`ifdef ARGMAX_TOP2_EN
    assign out_idx2 = idx2_q;
    assign out_max2 = max2_q;
`endif

endmodule
